// File: rtl/rr_arbiter_param_pkg.sv
// Shared types and helpers for the round-robin arbiter slice.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Widest requester vector the encode helper accepts.
  localparam int MAX_REQ   = 64;
  localparam int MAX_IDX_W = 6;

  // One-hot to binary encode; the OR form is exact for one-hot or zero input.
  function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | MAX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter_param_if.sv
// Requester-side bus of the round-robin arbiter: request/enable in, grant out.
interface rr_arbiter_param_if #(
  parameter int NUM_REQ = 8,
  parameter int IDX_W   = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
);

  logic               enable;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_valid;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_preempt;

  // Requesters drive enable/req and observe the grant.
  modport master (
    output enable, req,
    input  gnt, gnt_valid, gnt_idx, gnt_preempt
  );

  // The arbiter observes requests and drives the grant.
  modport slave (
    input  enable, req,
    output gnt, gnt_valid, gnt_idx, gnt_preempt
  );

endinterface

// File: rtl/rr_arbiter_param_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr.
module rr_pick
  import arb_pkg::*;
#(
  parameter int NUM_REQ = 8,
  parameter int IDX_W   = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [IDX_W-1:0]   win_idx,
  output logic               found
);

  localparam logic [IDX_W:0] N_L = (IDX_W+1)'(NUM_REQ);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [NUM_REQ-1:0]   iso;
  logic [IDX_W:0]       sum;
  logic [IDX_W:0]       wrapped;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, then map the
  // rotated offset back to an absolute index modulo NUM_REQ.
  always_comb begin
    dbl     = {req, req} >> ptr;
    rot     = dbl[NUM_REQ-1:0];
    iso     = rot & (~rot + NUM_REQ'(1));
    found   = |rot;
    sum     = {1'b0, ptr} + (IDX_W+1)'(onehot_to_idx(MAX_REQ'(iso)));
    wrapped = (sum >= N_L) ? (sum - N_L) : sum;
    win_idx = wrapped[IDX_W-1:0];
    win_oh  = found ? (NUM_REQ'(1) << win_idx) : '0;
  end

endmodule

// File: rtl/rr_arbiter_param.sv
// Round-robin arbiter with grant hold and optional hold-timeout preemption.
module rr_arbiter_param
  import arb_pkg::*;
#(
  parameter int NUM_REQ  = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic clk,
  input  logic rst_n,
  rr_arbiter_param_if.slave bus
);

  localparam int IDX_W  = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
  localparam int HOLD_W = ($clog2(MAX_HOLD + 1) > 1) ? $clog2(MAX_HOLD + 1) : 1;
  localparam bit TIMEOUT_EN = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LIM = TIMEOUT_EN ? HOLD_W'(MAX_HOLD - 1) : '0;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REQ - 1);

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [HOLD_W-1:0]  hold_cnt;

  logic [NUM_REQ-1:0] win_oh;
  logic [IDX_W-1:0]   win_idx;
  logic               found;
  logic               hold_req;
  logic               others_wait;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req     (bus.req),
    .ptr     (ptr),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .found   (found)
  );

  // Grantee still requesting, and whether anyone else is queued behind it.
  always_comb begin
    hold_req    = |(bus.req & bus.gnt);
    others_wait = |(bus.req & ~bus.gnt);
  end

  // FSM, pointer, hold counter and registered grant outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      ptr             <= '0;
      hold_cnt        <= '0;
      bus.gnt         <= '0;
      bus.gnt_valid   <= 1'b0;
      bus.gnt_idx     <= '0;
      bus.gnt_preempt <= 1'b0;
    end else begin
      bus.gnt_preempt <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.enable && found) begin
            bus.gnt       <= win_oh;
            bus.gnt_idx   <= win_idx;
            bus.gnt_valid <= 1'b1;
            ptr           <= (win_idx == LAST_IDX) ? '0 : win_idx + IDX_W'(1);
            hold_cnt      <= '0;
            state         <= BUSY;
          end
        end
        BUSY: begin
          // A dropped request wins over a coincident timeout: no preempt pulse.
          if (!hold_req) begin
            bus.gnt       <= '0;
            bus.gnt_valid <= 1'b0;
            state         <= IDLE;
          end else if (TIMEOUT_EN && (hold_cnt == HOLD_LIM) && others_wait) begin
            bus.gnt         <= '0;
            bus.gnt_valid   <= 1'b0;
            bus.gnt_preempt <= 1'b1;
            state           <= IDLE;
          end else if (hold_cnt != HOLD_LIM) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_param.sv
// Bench for rr_arbiter_param: an 8-way/MAX_HOLD=4 instance and a 5-way
// instance with timeout disabled, checked against a behavioural model.
module tb_rr_arbiter_param;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  rr_arbiter_param_if #(.NUM_REQ(8)) ifa ();
  rr_arbiter_param_if #(.NUM_REQ(5)) ifb ();

  rr_arbiter_param #(.NUM_REQ(8), .MAX_HOLD(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  rr_arbiter_param #(.NUM_REQ(5), .MAX_HOLD(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  int assert_cnt = 0;
  int fail_cnt   = 0;

  logic [7:0] req_a;
  logic       en_a;
  logic [4:0] req_b;
  logic       en_b;

  // Behavioural model: owner index (-1 = nobody), priority pointer,
  // visible grant cycles so far, last granted index, preempt pulse.
  int m_n  [2] = '{8, 5};
  int m_mh [2] = '{4, 0};
  int m_owner [2];
  int m_ptr   [2];
  int m_served[2];
  int m_last  [2];
  bit m_pre   [2];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_owner[i]  = -1;
      m_ptr[i]    = 0;
      m_served[i] = 0;
      m_last[i]   = 0;
      m_pre[i]    = 1'b0;
    end
  endfunction

  function automatic void model_step(input int i, input logic [7:0] rq, input logic en);
    m_pre[i] = 1'b0;
    if (m_owner[i] < 0) begin
      if (en && rq != 8'h00) begin
        for (int k = 0; k < m_n[i]; k++) begin
          int c;
          c = (m_ptr[i] + k) % m_n[i];
          if (rq[c]) begin
            m_owner[i]  = c;
            m_last[i]   = c;
            m_ptr[i]    = (c + 1) % m_n[i];
            m_served[i] = 1;
            break;
          end
        end
      end
    end else if (!rq[m_owner[i]]) begin
      m_owner[i] = -1;
    end else if (m_mh[i] != 0 && m_served[i] >= m_mh[i] &&
                 (rq & ~(8'd1 << m_owner[i])) != 8'h00) begin
      m_owner[i] = -1;
      m_pre[i]   = 1'b1;
    end else begin
      m_served[i]++;
    end
  endfunction

  function automatic logic [63:0] exp_gnt(input int i);
    return (m_owner[i] < 0) ? 64'd0 : (64'd1 << m_owner[i]);
  endfunction

  task automatic compare_all();
    check_val("a_gnt",     64'(ifa.gnt),         exp_gnt(0));
    check_val("a_valid",   64'(ifa.gnt_valid),   64'(m_owner[0] >= 0));
    check_val("a_idx",     64'(ifa.gnt_idx),     64'(m_last[0]));
    check_val("a_preempt", 64'(ifa.gnt_preempt), 64'(m_pre[0]));
    check_val("b_gnt",     64'(ifb.gnt),         exp_gnt(1));
    check_val("b_valid",   64'(ifb.gnt_valid),   64'(m_owner[1] >= 0));
    check_val("b_idx",     64'(ifb.gnt_idx),     64'(m_last[1]));
    check_val("b_preempt", 64'(ifb.gnt_preempt), 64'(m_pre[1]));
  endtask

  task automatic step();
    @(negedge clk);
    ifa.req = req_a; ifa.enable = en_a;
    ifb.req = req_b; ifb.enable = en_b;
    @(posedge clk);
    model_step(0, req_a, en_a);
    model_step(1, {3'b000, req_b}, en_b);
    #1;
    compare_all();
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_a_gnt",     64'(ifa.gnt),         64'd0);
    check_val("rst_a_valid",   64'(ifa.gnt_valid),   64'd0);
    check_val("rst_a_idx",     64'(ifa.gnt_idx),     64'd0);
    check_val("rst_a_preempt", 64'(ifa.gnt_preempt), 64'd0);
    check_val("rst_b_gnt",     64'(ifb.gnt),         64'd0);
    model_reset();
    req_a = '0; en_a = 1'b0; req_b = '0; en_b = 1'b0;
    @(negedge clk);
    ifa.req = '0; ifa.enable = 1'b0; ifb.req = '0; ifb.enable = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] g [1:10];
    logic       p [1:10];
    logic [2:0] ix[1:10];
    int         cnt;
    int         q[$];
    logic       prev_v;

    rst_n = 1'b0;
    req_a = '0; en_a = 1'b0; req_b = '0; en_b = 1'b0;
    ifa.req = '0; ifa.enable = 1'b0; ifb.req = '0; ifb.enable = 1'b0;
    model_reset();
    #12;
    check_val("init_gnt",   64'(ifa.gnt),       64'd0);
    check_val("init_valid", 64'(ifa.gnt_valid), 64'd0);
    check_val("init_idx",   64'(ifa.gnt_idx),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic grant, release bubble, pointer advance.
    req_a = 8'b0010_0100; en_a = 1'b1;
    step();
    check_val("t1_gnt", 64'(ifa.gnt), 64'h04);
    check_val("t1_idx", 64'(ifa.gnt_idx), 64'd2);
    req_a = 8'b0010_0000;
    step();
    check_val("t1_bubble", 64'(ifa.gnt), 64'h00);
    step();
    check_val("t1_gnt2", 64'(ifa.gnt), 64'h20);
    check_val("t1_idx2", 64'(ifa.gnt_idx), 64'd5);

    // Fairness: all requesting, each grantee leaves after 3 cycles.
    async_reset();
    en_a = 1'b1;
    prev_v = 1'b0;
    for (int s = 0; s < 80 && q.size() < 9; s++) begin
      req_a = 8'hFF;
      if (m_owner[0] >= 0 && m_served[0] >= 3) req_a[m_owner[0]] = 1'b0;
      step();
      if (ifa.gnt_valid && !prev_v) q.push_back(int'(ifa.gnt_idx));
      prev_v = ifa.gnt_valid;
    end
    check_val("fair_cnt", 64'(q.size()), 64'd9);
    for (int k = 0; k < q.size(); k++) check_val("fair_seq", 64'(q[k]), 64'(k % 8));

    // Timeout: 3 held with 6 waiting.
    async_reset();
    req_a = 8'h48; en_a = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      g[c] = ifa.gnt; p[c] = ifa.gnt_preempt; ix[c] = ifa.gnt_idx;
    end
    cnt = 0;
    for (int c = 1; c <= 10; c++) if (g[c] == 8'h08) cnt++;
    check_val("to_hold", 64'(cnt), 64'd4);
    check_val("to_pre",  64'(p[5]), 64'd1);
    check_val("to_gap",  64'(g[5]), 64'd0);
    check_val("to_next", 64'(ix[6]), 64'd6);
    check_val("to_ngnt", 64'(g[6]), 64'h40);

    // Lone requester is never preempted.
    async_reset();
    req_a = 8'h08; en_a = 1'b1;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (ifa.gnt_preempt) cnt++;
    end
    check_val("lone_pre", 64'(cnt), 64'd0);
    check_val("lone_gnt", 64'(ifa.gnt), 64'h08);

    // Enable gates only entry into a grant.
    async_reset();
    req_a = 8'h81; en_a = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check_val("en_off", 64'(ifa.gnt), 64'd0);
    end
    en_a = 1'b1;
    step();
    check_val("en_on_idx", 64'(ifa.gnt_idx), 64'd0);
    check_val("en_on_v",   64'(ifa.gnt_valid), 64'd1);
    en_a = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check_val("en_hold", 64'(ifa.gnt), 64'h01);
    end
    req_a = 8'h80;
    for (int c = 0; c < 4; c++) begin
      step();
      check_val("en_nogrant", 64'(ifa.gnt), 64'd0);
    end

    // Async reset while busy, then first grant from fresh pointer.
    async_reset();
    req_a = 8'hFF; en_a = 1'b1;
    step(); step();
    check_val("ar_busy", 64'(ifa.gnt_valid), 64'd1);
    async_reset();
    req_a = 8'hFF; en_a = 1'b1;
    step();
    check_val("ar_first", 64'(ifa.gnt_idx), 64'd0);
    check_val("ar_gnt",   64'(ifa.gnt), 64'h01);

    // 5-way wrap: ptr reaches 4, then 0 wins, then ptr=1 makes 1 win.
    async_reset();
    en_b = 1'b1;
    req_b = 5'b01000; step();
    check_val("w_g3", 64'(ifb.gnt_idx), 64'd3);
    req_b = 5'b00011; step();
    step();
    check_val("w_g0",  64'(ifb.gnt_idx), 64'd0);
    check_val("w_gnt", 64'(ifb.gnt), 64'h01);
    req_b = 5'b00010; step();
    req_b = 5'b00011; step();
    check_val("w_g1", 64'(ifb.gnt_idx), 64'd1);

    // Randomized traffic on both instances.
    async_reset();
    for (int s = 0; s < 800; s++) begin
      for (int b = 0; b < 8; b++) if ($urandom_range(9) == 0) req_a[b] = ~req_a[b];
      for (int b = 0; b < 5; b++) if ($urandom_range(9) == 0) req_b[b] = ~req_b[b];
      en_a = ($urandom_range(4) != 0);
      en_b = ($urandom_range(4) != 0);
      if ($urandom_range(299) == 0) async_reset();
      else step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_param.md
Name: rr_arbiter_param

Overview:
Parametrised round-robin arbiter granting one of NUM_REQ requesters (e.g. boards/channels) exclusive access to a shared resource.
- Successor to the fixed 8-way board selector. Adds a true rotating-priority pointer, grant hold while the request stays asserted, and optional hold-timeout preemption.
- Outputs both a one-hot grant and an encoded index with an explicit valid flag, replacing the out-of-range "invalid" index code.

Parameters:
- NUM_REQ, 8, number of requesters, ≥2.
- MAX_HOLD, 16, max consecutive grant cycles before forced release when others wait; 0 disables timeout.
- IDX_W (localparam), max(1,$clog2(NUM_REQ)), grant index width.
- HOLD_W (localparam), max(1,$clog2(MAX_HOLD+1)), hold counter width.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  permits new grants; does not revoke an active grant.
- req  input  NUM_REQ  request vector; bit i held high while requester i wants or uses the resource.
- gnt  output  NUM_REQ  registered one-hot grant; all-zero when idle.
- gnt_valid  output  1  high iff gnt is non-zero.
- gnt_idx  output  IDX_W  binary index of the granted requester; valid only with gnt_valid.
- gnt_preempt  output  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset (async, rst_n low):
  - gnt=0, gnt_valid=0, gnt_idx=0, gnt_preempt=0.
  - State IDLE, ptr=0, hold_cnt=0.
  - Takes effect immediately mid-grant; no handshake with the grantee.
- ptr: highest-priority index for the next arbitration. Search order is ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1.
- IDLE:
  - On a clk edge with enable=1 and |req, select winner w = first set req bit in search order.
  - Next cycle: gnt=1<<w, gnt_idx=w, gnt_valid=1.
  - ptr <= (w+1) mod NUM_REQ, wrapping at NUM_REQ-1 → 0 (NUM_REQ need not be a power of 2).
  - hold_cnt <= 0; go to BUSY.
  - Latency from req to gnt is 1 cycle.
  - If enable=0 or req=0, stay IDLE with outputs 0.
- BUSY (grant held on winner w):
  - Normal release: req[w]=0 at an edge → gnt=0, gnt_valid=0; go to IDLE. gnt_idx retains its last value.
  - Timeout release: MAX_HOLD≠0, hold_cnt==MAX_HOLD-1, and any other req bit set → release as above, gnt_preempt=1 for that one cycle.
  - Otherwise hold_cnt increments, saturating at MAX_HOLD-1, and the grant holds.
  - A lone requester is never preempted.
- Simultaneous req[w] drop and timeout: treat as a normal release, no preempt pulse.
- Release always produces exactly one cycle of gnt=0 before the next grant (one-bubble handover). The new arbitration happens at the edge after the release edge, using ptr already advanced past w.
- enable=0 in BUSY: the grant continues; release and timeout still apply. Deasserting enable only blocks entry into BUSY.
- Requests appearing or vanishing for non-granted bits in BUSY do not affect gnt.
- Fairness: with all bits continuously requesting and each grantee dropping its request after service, grants cycle 0,1,…,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 grants.
- Invariants:
  - gnt is one-hot or zero.
  - gnt_valid == |gnt.
  - gnt_preempt implies gnt==0 in the same cycle.

Decomposition:
- Package arb_pkg: state enum {IDLE, BUSY}, and function onehot_to_idx for the grant encode.
- Sub-module rr_pick (combinational): inputs req and ptr; outputs winner one-hot and winner idx plus a found flag. Implementation: rotate, find rightmost-1 via x & (~x+1), rotate back; or a double-width masked search.
- Top level holds the FSM, ptr, hold_cnt and output registers.

Test Plan:
- Reset then req=8'b0010_0100, enable=1 → one cycle later gnt=8'b0000_0100, gnt_idx=2, ptr=3. Drop req[2] → gnt=0 one cycle, then gnt=8'b0010_0000, gnt_idx=5.
- req=8'hFF constant, each grantee drops its bit for one cycle after 3 cycles of service → grant sequence 0,1,2,…,7,0 with one idle cycle between grants.
- MAX_HOLD=4, req[3] held with req[6] high → gnt on 3 for exactly 4 cycles, then gnt=0 with gnt_preempt=1, next grant idx 6. Repeat with only req[3] high → no preempt, grant held indefinitely.
- enable=0 with req=8'h81 → gnt stays 0. Raise enable mid-stream → grant idx 0. Lower enable while BUSY → grant persists until req[0] drops; then no new grant.
- Assert rst_n=0 asynchronously between edges while BUSY → gnt, gnt_valid, gnt_preempt go 0 immediately. After release, the first grant with req=8'hFF is idx 0.
- NUM_REQ=5: ptr at 4, req=5'b00011 → grant idx 0 (wrap), next ptr=1.
